// File: rtl/transport_receive.sv
// rtl/transport_receive.sv - receive-side transport layer: packet parser, control register, audio FWFT FIFO

module transport_receive #(
  parameter int         PACKET_BYTES = 16,
  parameter int         AUDIO_DEPTH  = 16,
  parameter logic [7:0] HDR_CTRL     = 8'h40,
  parameter logic [7:0] HDR_AUDIO    = 8'h80
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           rxFrame,
  input  logic                           rxValid,
  input  logic [7:0]                     rxByte,
  output logic [15:0]                    ctrlData,
  output logic                           ctrlValid,
  input  logic                           ctrlAck,
  output logic [15:0]                    audioData,
  output logic                           audioEmpty,
  input  logic                           audioRead,
  output logic [$clog2(AUDIO_DEPTH):0]   audioCount,
  output logic                           busy,
  output logic                           badHeader,
  output logic                           runt,
  output logic                           ctrlOverrun,
  output logic                           audioOverflow
);

  // Byte counter must be able to hold PACKET_BYTES itself.
  localparam int CW = $clog2(PACKET_BYTES + 1);
  localparam int AW = $clog2(AUDIO_DEPTH);
  localparam int NW = AW + 1;

  localparam logic [CW-1:0] PKT_LEN     = CW'(PACKET_BYTES);
  // A sample may start only if its low byte still fits: accepted byte count
  // after the low byte must leave at least two bytes for another sample.
  localparam logic [CW-1:0] LAST_PAIR   = CW'(PACKET_BYTES - 2);
  localparam logic [NW-1:0] FIFO_FULL   = NW'(AUDIO_DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CTRL_HI = 3'd1,
    CTRL_LO = 3'd2,
    AUD_HI  = 3'd3,
    AUD_LO  = 3'd4,
    DRAIN   = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_inc;
  logic [7:0]      hi_q, hi_d;

  // Parser events, combinational, consumed by the register/FIFO blocks below.
  logic            ctrl_wr;
  logic            sample_push;
  logic            bad_hdr_ev;
  logic            runt_ev;
  logic [15:0]     rx_word;

  logic            bad_hdr_q;
  logic            runt_q;

  logic [15:0]     ctrl_data_q;
  logic            ctrl_valid_q;
  logic            ctrl_ovr_q;

  logic [15:0]     mem_q [AUDIO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [NW-1:0]   count_q, count_d;
  logic            fifo_empty;
  logic            fifo_full;
  logic            do_read;
  logic            do_write;
  logic            ovf_ev;
  logic            ovf_q;

  assign rx_word = {hi_q, rxByte};

  // ---------------------------------------------------------------------------
  // Packet parser
  // ---------------------------------------------------------------------------

  // State, byte counter and held high byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
    end
  end

  // Next-state decode: header dispatch, field extraction, runt and packet end.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    cnt_inc     = cnt_q + 1'b1;
    ctrl_wr     = 1'b0;
    sample_push = 1'b0;
    bad_hdr_ev  = 1'b0;
    runt_ev     = 1'b0;

    if (!rxFrame) begin
      // Frame dropped: anything half-parsed is abandoned.
      if (state_q != IDLE) begin
        runt_ev = 1'b1;
      end
      state_d = IDLE;
      cnt_d   = '0;
    end else if (rxValid) begin
      case (state_q)
        IDLE: begin
          if (rxByte == HDR_CTRL) begin
            state_d = CTRL_HI;
          end else if (rxByte == HDR_AUDIO) begin
            state_d = AUD_HI;
          end else begin
            bad_hdr_ev = 1'b1;
            state_d    = DRAIN;
          end
        end
        CTRL_HI: begin
          hi_d    = rxByte;
          state_d = CTRL_LO;
        end
        CTRL_LO: begin
          ctrl_wr = 1'b1;
          state_d = DRAIN;
        end
        AUD_HI: begin
          hi_d    = rxByte;
          state_d = AUD_LO;
        end
        AUD_LO: begin
          sample_push = 1'b1;
          state_d     = (cnt_inc <= LAST_PAIR) ? AUD_HI : DRAIN;
        end
        DRAIN: begin
          state_d = DRAIN;
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      // The byte that completes the packet always returns to IDLE.
      if (cnt_inc == PKT_LEN) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  // Registered error pulses from the parser.
  always_ff @(posedge clk) begin
    if (reset) begin
      bad_hdr_q <= 1'b0;
      runt_q    <= 1'b0;
    end else begin
      bad_hdr_q <= bad_hdr_ev;
      runt_q    <= runt_ev;
    end
  end

  // ---------------------------------------------------------------------------
  // Control word register
  // ---------------------------------------------------------------------------

  // Latch control words; a new word beats a simultaneous ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_data_q  <= '0;
      ctrl_valid_q <= 1'b0;
      ctrl_ovr_q   <= 1'b0;
    end else begin
      ctrl_ovr_q <= ctrl_wr && ctrl_valid_q && !ctrlAck;
      if (ctrl_wr) begin
        ctrl_data_q  <= rx_word;
        ctrl_valid_q <= 1'b1;
      end else if (ctrlAck) begin
        ctrl_valid_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Audio FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FIFO_FULL);
  assign do_read    = audioRead && !fifo_empty;
  // A full FIFO still accepts a sample when the head is popped in the same cycle.
  assign do_write   = sample_push && (!fifo_full || do_read);
  assign ovf_ev     = sample_push && fifo_full && !do_read;

  // Occupancy update from the accepted push/pop pair.
  always_comb begin
    count_d = count_q;
    if (do_write && !do_read) begin
      count_d = count_q + 1'b1;
    end else if (do_read && !do_write) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointers, occupancy and overflow pulse; pointers wrap naturally at AUDIO_DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_ev;
      if (do_write) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_read) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Sample storage; contents are qualified by the occupancy, so no reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_q[wr_ptr_q] <= rx_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------

  assign ctrlData      = ctrl_data_q;
  assign ctrlValid     = ctrl_valid_q;
  // Head word is forced to zero while empty so stale storage never leaks out.
  assign audioData     = fifo_empty ? 16'h0000 : mem_q[rd_ptr_q];
  assign audioEmpty    = fifo_empty;
  assign audioCount    = count_q;
  assign busy          = (state_q != IDLE);
  assign badHeader     = bad_hdr_q;
  assign runt          = runt_q;
  assign ctrlOverrun   = ctrl_ovr_q;
  assign audioOverflow = ovf_q;

endmodule

// File: tb/tb_transport_receive.sv
// tb/tb_transport_receive.sv - scoreboard bench for transport_receive

module tb_transport_receive;

  logic        clk = 1'b0;
  logic        reset;
  logic        rxFrame;
  logic        rxValid;
  logic [7:0]  rxByte;
  logic [15:0] ctrlData;
  logic        ctrlValid;
  logic        ctrlAck;
  logic [15:0] audioData;
  logic        audioEmpty;
  logic        audioRead;
  logic [4:0]  audioCount;
  logic        busy;
  logic        badHeader;
  logic        runt;
  logic        ctrlOverrun;
  logic        audioOverflow;

  always #5 clk = ~clk;

  transport_receive dut (
    .clk          (clk),
    .reset        (reset),
    .rxFrame      (rxFrame),
    .rxValid      (rxValid),
    .rxByte       (rxByte),
    .ctrlData     (ctrlData),
    .ctrlValid    (ctrlValid),
    .ctrlAck      (ctrlAck),
    .audioData    (audioData),
    .audioEmpty   (audioEmpty),
    .audioRead    (audioRead),
    .audioCount   (audioCount),
    .busy         (busy),
    .badHeader    (badHeader),
    .runt         (runt),
    .ctrlOverrun  (ctrlOverrun),
    .audioOverflow(audioOverflow)
  );

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_audio [$];
  logic [15:0] exp_ctrl  [$];

  int n_bad  = 0;
  int n_runt = 0;
  int n_ovr  = 0;
  int n_ovf  = 0;

  logic        prev_valid = 1'b0;
  logic [15:0] prev_data  = 16'h0;

  logic [7:0]  pkt [16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Monitor: counts pulses, checks every popped sample and every new control word.
  always @(negedge clk) begin
    if (badHeader)     n_bad++;
    if (runt)          n_runt++;
    if (ctrlOverrun)   n_ovr++;
    if (audioOverflow) n_ovf++;
    if (reset) begin
      prev_valid = 1'b0;
      prev_data  = 16'h0;
    end else begin
      if (audioRead && !audioEmpty) begin
        if (exp_audio.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL audio_unexpected got=%0h expected=none", audioData);
        end else begin
          check("audio_pop", {16'h0, audioData}, {16'h0, exp_audio.pop_front()});
        end
      end
      if (ctrlValid && (!prev_valid || ctrlData != prev_data)) begin
        if (exp_ctrl.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL ctrl_unexpected got=%0h expected=none", ctrlData);
        end else begin
          check("ctrl_word", {16'h0, ctrlData}, {16'h0, exp_ctrl.pop_front()});
        end
      end
      prev_valid = ctrlValid;
      prev_data  = ctrlData;
    end
  end

  task automatic build_ctrl(input logic [15:0] w);
    for (int i = 0; i < 16; i++) pkt[i] = 8'h00;
    pkt[0] = 8'h40;
    pkt[1] = w[15:8];
    pkt[2] = w[7:0];
  endtask

  task automatic build_audio(input logic [15:0] base);
    logic [15:0] s;
    pkt[0] = 8'h80;
    for (int j = 0; j < 7; j++) begin
      s = base + 16'(j);
      pkt[1 + 2*j] = s[15:8];
      pkt[2 + 2*j] = s[7:0];
    end
    pkt[15] = 8'h00;
  endtask

  // Deliver bytes k0..k1 (1-based) of pkt; expected words go to the scoreboard.
  task automatic send_pkt(input int k0, input int k1, input bit stall,
                          input int read_at, input int ack_at);
    for (int k = k0; k <= k1; k++) begin
      if (stall) begin
        rxFrame = 1'b1;
        rxValid = 1'b0;
        @(posedge clk); #1;
      end
      rxFrame   = 1'b1;
      rxValid   = 1'b1;
      rxByte    = pkt[k-1];
      audioRead = (k == read_at);
      ctrlAck   = (k == ack_at);
      @(posedge clk); #1;
      rxValid   = 1'b0;
      audioRead = 1'b0;
      ctrlAck   = 1'b0;
      if (pkt[0] == 8'h80 && k >= 3 && k <= 15 && (k % 2) == 1) begin
        if (exp_audio.size() < 16) exp_audio.push_back({pkt[k-2], pkt[k-1]});
      end
      if (pkt[0] == 8'h40 && k == 3) exp_ctrl.push_back({pkt[1], pkt[2]});
    end
  endtask

  task automatic idle(input int n);
    rxFrame = 1'b0;
    rxValid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ack();
    ctrlAck = 1'b1;
    @(posedge clk); #1;
    ctrlAck = 1'b0;
  endtask

  task automatic pop_all(input string name);
    int budget;
    budget = 64;
    audioRead = 1'b1;
    while (!audioEmpty && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    audioRead = 1'b0;
    check({name, "_empty"}, {31'h0, audioEmpty}, 32'd1);
    check({name, "_all_popped"}, exp_audio.size(), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, r0, o0, f0;
    reset = 1'b1; rxFrame = 1'b0; rxValid = 1'b0; rxByte = 8'h00;
    ctrlAck = 1'b0; audioRead = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_ctrlValid",  {31'h0, ctrlValid},  32'd0);
    check("rst_ctrlData",   {16'h0, ctrlData},   32'd0);
    check("rst_audioEmpty", {31'h0, audioEmpty}, 32'd1);
    check("rst_audioCount", {27'h0, audioCount}, 32'd0);
    check("rst_audioData",  {16'h0, audioData},  32'd0);
    check("rst_busy",       {31'h0, busy},       32'd0);

    // Control packet 40,12,34 then 13 pad bytes.
    b0 = n_bad; r0 = n_runt; o0 = n_ovr; f0 = n_ovf;
    build_ctrl(16'h1234);
    send_pkt(1, 2, 1'b0, 0, 0);
    check("t1_valid_before_lo", {31'h0, ctrlValid}, 32'd0);
    send_pkt(3, 3, 1'b0, 0, 0);
    check("t1_valid_after_lo", {31'h0, ctrlValid}, 32'd1);
    check("t1_data", {16'h0, ctrlData}, 32'h1234);
    send_pkt(4, 15, 1'b0, 0, 0);
    check("t1_busy_mid", {31'h0, busy}, 32'd1);
    send_pkt(16, 16, 1'b0, 0, 0);
    check("t1_busy_end", {31'h0, busy}, 32'd0);
    idle(2);
    check("t1_no_errors", n_bad + n_runt + n_ovr + n_ovf - b0 - r0 - o0 - f0, 32'd0);
    ack();
    check("t1_ack_clears", {31'h0, ctrlValid}, 32'd0);

    // Audio packet with alternate-cycle stalls.
    build_audio(16'h0001);
    send_pkt(1, 16, 1'b1, 0, 0);
    idle(2);
    check("t2_count", {27'h0, audioCount}, 32'd7);
    pop_all("t2");

    // Bad header, then a control packet back-to-back.
    b0 = n_bad;
    for (int i = 0; i < 16; i++) pkt[i] = 8'h00;
    pkt[0] = 8'h55;
    send_pkt(1, 16, 1'b0, 0, 0);
    check("t3_no_fifo_write", {27'h0, audioCount}, 32'd0);
    check("t3_no_ctrl_write", {31'h0, ctrlValid}, 32'd0);
    build_ctrl(16'hABCD);
    send_pkt(1, 16, 1'b0, 0, 0);
    idle(2);
    check("t3_badHeader_pulses", n_bad - b0, 32'd1);
    check("t3_data", {16'h0, ctrlData}, 32'hABCD);
    ack();

    // Runt: 80,11,22,33 then frame drop.
    r0 = n_runt;
    pkt[0] = 8'h80; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33;
    send_pkt(1, 4, 1'b0, 0, 0);
    idle(2);
    check("t4_runt_pulses", n_runt - r0, 32'd1);
    check("t4_count", {27'h0, audioCount}, 32'd1);
    check("t4_busy", {31'h0, busy}, 32'd0);
    build_audio(16'h0301);
    send_pkt(1, 16, 1'b0, 0, 0);
    idle(2);
    check("t4_count_after", {27'h0, audioCount}, 32'd8);
    check("t4_runt_once", n_runt - r0, 32'd1);
    pop_all("t4");

    // Overflow: 21 samples into a 16-deep FIFO.
    f0 = n_ovf;
    build_audio(16'h0100); send_pkt(1, 16, 1'b0, 0, 0);
    build_audio(16'h0107); send_pkt(1, 16, 1'b0, 0, 0);
    build_audio(16'h010E); send_pkt(1, 16, 1'b0, 0, 0);
    idle(2);
    check("t5_count_full", {27'h0, audioCount}, 32'd16);
    check("t5_overflows", n_ovf - f0, 32'd5);
    pop_all("t5a");

    // Refill, reading on the first push that lands on a full FIFO (byte 7 of packet 3).
    f0 = n_ovf;
    build_audio(16'h0200); send_pkt(1, 16, 1'b0, 0, 0);
    build_audio(16'h0207); send_pkt(1, 16, 1'b0, 0, 0);
    build_audio(16'h020E); send_pkt(1, 6, 1'b0, 0, 0);
    check("t5_full_before_read", {27'h0, audioCount}, 32'd16);
    send_pkt(7, 7, 1'b0, 7, 0);
    check("t5_count_push_read", {27'h0, audioCount}, 32'd16);
    send_pkt(8, 16, 1'b0, 0, 0);
    idle(2);
    check("t5_overflows_with_read", n_ovf - f0, 32'd4);
    pop_all("t5b");

    // Control overrun, then ack colliding with a new word.
    o0 = n_ovr;
    build_ctrl(16'h1111); send_pkt(1, 16, 1'b0, 0, 0);
    build_ctrl(16'h2222); send_pkt(1, 16, 1'b0, 0, 0);
    idle(2);
    check("t6_overrun", n_ovr - o0, 32'd1);
    check("t6_data", {16'h0, ctrlData}, 32'h2222);
    ack();
    o0 = n_ovr;
    build_ctrl(16'h3333); send_pkt(1, 16, 1'b0, 0, 0);
    build_ctrl(16'h4444); send_pkt(1, 16, 1'b0, 0, 3);
    idle(2);
    check("t6_no_overrun_on_ack", n_ovr - o0, 32'd0);
    check("t6_valid_kept", {31'h0, ctrlValid}, 32'd1);
    check("t6_data_new", {16'h0, ctrlData}, 32'h4444);

    // Reset in the middle of an audio packet.
    b0 = n_bad; r0 = n_runt; o0 = n_ovr; f0 = n_ovf;
    build_audio(16'h0102);
    send_pkt(1, 5, 1'b0, 0, 0);
    reset = 1'b1;
    rxFrame = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_audio.delete();
    exp_ctrl.delete();
    idle(3);
    check("t7_ctrlValid",  {31'h0, ctrlValid},  32'd0);
    check("t7_ctrlData",   {16'h0, ctrlData},   32'd0);
    check("t7_audioEmpty", {31'h0, audioEmpty}, 32'd1);
    check("t7_audioCount", {27'h0, audioCount}, 32'd0);
    check("t7_audioData",  {16'h0, audioData},  32'd0);
    check("t7_busy",       {31'h0, busy},       32'd0);
    check("t7_no_pulses", n_bad + n_runt + n_ovr + n_ovf - b0 - r0 - o0 - f0, 32'd0);

    // Parser still works after reset.
    build_ctrl(16'h5A5A);
    send_pkt(1, 16, 1'b0, 0, 0);
    idle(2);
    check("t7_post_reset_data", {16'h0, ctrlData}, 32'h5A5A);
    check("final_ctrl_consumed", exp_ctrl.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/transport_receive.md
Name: transport_receive

Overview:
- Receive-side transport layer for the phone link. Parses the byte stream produced by the send-side transport block: one header byte, payload, then zero padding, PACKET_BYTES bytes per packet.
- Control packets yield one 16-bit control word behind a valid/ack register.
- Audio packets yield 16-bit samples into an internal first-word-fall-through FIFO that the audio path drains.
- Sits between the link/PHY byte deframer and the call-control FSM and audio playback path.

Parameters:
- PACKET_BYTES, 16, bytes per packet including header (fixed framing, 128 bits).
- AUDIO_DEPTH, 16, audio FIFO depth in 16-bit words; power of two, at least 4.
- HDR_CTRL, 8'h40, header byte marking a control packet.
- HDR_AUDIO, 8'h80, header byte marking an audio packet.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- rxFrame  in  1  high while a packet is being delivered.
- rxValid  in  1  rxByte is valid this cycle. A byte is accepted only when rxValid && rxFrame.
- rxByte  in  8  packet byte, MSB-first order within 16-bit fields.
- ctrlData  out  16  last received control word.
- ctrlValid  out  1  ctrlData holds an unacknowledged word.
- ctrlAck  in  1  consumer acknowledge; clears ctrlValid.
- audioData  out  16  FIFO head word, valid when !audioEmpty.
- audioEmpty  out  1  FIFO empty.
- audioRead  in  1  pop the FIFO head.
- audioCount  out  $clog2(AUDIO_DEPTH)+1  FIFO occupancy, 0..AUDIO_DEPTH.
- busy  out  1  packet in progress (state != IDLE).
- badHeader  out  1  one-cycle pulse: unknown header byte.
- runt  out  1  one-cycle pulse: rxFrame fell before the packet completed.
- ctrlOverrun  out  1  one-cycle pulse: control word overwritten before ack.
- audioOverflow  out  1  one-cycle pulse: sample dropped because the FIFO was full.

Behaviour:

Reset:
- All outputs clear to 0, except audioEmpty = 1.
- FIFO pointers and audioCount go to 0; ctrlData = 0; state = IDLE; byteCnt = 0.
- Reset mid-packet discards the partial packet and raises no error pulses.

Byte counter:
- byteCnt counts accepted bytes of the current packet, header included.
- The packet ends on the accepted byte that makes byteCnt == PACKET_BYTES. The FSM then returns to IDLE and byteCnt goes to 0.

FSM states: IDLE, CTRL_HI, CTRL_LO, AUD_HI, AUD_LO, DRAIN.
- IDLE, accepted byte == HDR_CTRL: go to CTRL_HI.
- IDLE, accepted byte == HDR_AUDIO: go to AUD_HI.
- IDLE, any other accepted byte: pulse badHeader, go to DRAIN.
- CTRL_HI: latch the high byte, go to CTRL_LO.
- CTRL_LO: write the word to ctrlData, go to DRAIN.
- AUD_HI: latch the high byte, go to AUD_LO.
- AUD_LO: push the sample. Next state is AUD_HI if at least 2 packet bytes remain, else DRAIN (or IDLE if the packet is complete).
  - Default framing is 7 samples plus 1 pad byte per packet.
- DRAIN: discard bytes, no checking of pad values, until the packet is complete.
- Cycles with rxValid low inside a frame are stalls: no state change.

Runt handling:
- If rxFrame is low in any state other than IDLE, pulse runt and go to IDLE.
- A half-received sample or control word is discarded. Samples already pushed remain in the FIFO.

Back-to-back packets:
- If rxFrame stays high after a packet completes, the next accepted byte is a new header.

Control register:
- ctrlValid rises the cycle after the low byte is accepted.
- ctrlAck clears ctrlValid on the next edge.
- New word while ctrlValid = 1 and no ack: overwrite ctrlData, ctrlValid stays 1, pulse ctrlOverrun.
- New word and ctrlAck in the same cycle: new word wins, ctrlValid stays 1, no overrun.

Audio FIFO (first-word-fall-through):
- A pushed sample is visible on audioData, with audioEmpty = 0, the cycle after its low byte is accepted.
- audioRead while empty: ignored.
- Push while full with no read: sample dropped, pulse audioOverflow, count unchanged.
- Push and read in the same cycle while full: both occur, count stays AUDIO_DEPTH.
- Push and read in the same cycle, otherwise: count unchanged.
- Pointers wrap modulo AUDIO_DEPTH.

Test Plan:
- **Control packet.** Send 40,12,34 then 13x00 with rxFrame high throughout. Required: ctrlData = 16'h1234 and ctrlValid = 1 one cycle after byte 3; busy falls after byte 16; no error pulses. Then ctrlAck = 1 for one cycle: ctrlValid = 0.
- **Audio packet with stalls.** Send 80, then samples 0001..0007 as byte pairs, then pad 00, with rxValid low on alternate cycles. Required: audioCount = 7; pops return 0001..0007 in order; audioEmpty = 1 afterwards.
- **Bad header then valid packet.** Send header 55 and 15 bytes, then a control packet carrying ABCD back-to-back. Required: badHeader pulses once; no FIFO or control writes during the first packet; ctrlData = ABCD.
- **Runt.** Send 80,11,22,33, then drop rxFrame. Required: runt pulses once; FIFO holds only 1122; state returns to IDLE; the next packet parses correctly.
- **Overflow and full-boundary read.** Send 3 audio packets (21 samples) without reads, AUDIO_DEPTH = 16. Required: audioCount = 16 and 5 audioOverflow pulses. Then repeat the fill with audioRead held on the final push: count stays 16 and no overflow pulse on that cycle.
- **Control overrun, ack collision, and reset.** Send two control packets with no ack: ctrlOverrun pulses once, ctrlData = second word. Repeat with ctrlAck coinciding with the second word's write: no pulse, ctrlValid = 1. Assert reset mid-audio-packet: all outputs cleared, audioEmpty = 1, no pulses.
